// File: rtl/count_sequencer.sv
// Run-control sequencer for the binary counter datapath.
// Programmable terminal value, prescale ratio and one-shot/continuous mode.
module count_sequencer #(
    parameter int WIDTH      = 4,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [WIDTH-1:0]      cfg_limit,
    input  logic [PRESCALE_W-1:0] cfg_prescale,
    input  logic                  cfg_oneshot,
    input  logic                  start,
    input  logic                  stop,
    output logic [WIDTH-1:0]      count,
    output logic                  tick,
    output logic                  wrap,
    output logic                  done,
    output logic                  busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [WIDTH-1:0]      r_limit;
    logic [PRESCALE_W-1:0] r_prescale;
    logic                  r_oneshot;

    logic [PRESCALE_W-1:0] r_presc;
    logic [WIDTH-1:0]      r_count;
    logic                  r_tick;
    logic                  r_wrap;
    logic                  r_done;
    logic                  r_busy;
    logic                  r_cfg_ready;

    logic [PRESCALE_W-1:0] w_presc_nxt;
    logic [WIDTH-1:0]      w_count_nxt;
    logic                  w_tick_nxt;
    logic                  w_wrap_nxt;
    logic                  w_done_nxt;
    logic                  w_busy_nxt;
    logic                  w_cfg_ready_nxt;

    logic w_cfg_take;
    logic w_start;
    logic w_adv;
    logic w_at_lim;
    logic w_finish;

    // stop has priority over start whenever both are offered
    assign w_start    = start & ~stop;
    assign w_cfg_take = cfg_valid & r_cfg_ready;
    assign w_adv      = (r_state == S_RUN) && (r_presc == r_prescale);
    assign w_at_lim   = (r_count >= r_limit);
    assign w_finish   = w_adv & w_at_lim & r_oneshot;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_limit    <= '1;
            r_prescale <= '0;
            r_oneshot  <= 1'b0;
        end else if (w_cfg_take) begin
            r_limit    <= cfg_limit;
            r_prescale <= cfg_prescale;
            r_oneshot  <= cfg_oneshot;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                // an advance landing with stop still completes first
                if (w_finish) begin
                    w_state_nxt = S_DONE;
                end else if (stop) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                end else if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_presc_nxt = r_presc;
        w_count_nxt = r_count;
        w_tick_nxt  = 1'b0;
        w_wrap_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start) begin
                    w_presc_nxt = '0;
                    w_count_nxt = '0;
                end
            end
            S_RUN: begin
                if (w_adv) begin
                    w_presc_nxt = '0;
                    w_tick_nxt  = 1'b1;
                    if (!w_at_lim) begin
                        w_count_nxt = r_count + 1'b1;
                    end else if (r_oneshot) begin
                        w_count_nxt = r_limit;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_count_nxt = '0;
                        w_wrap_nxt  = 1'b1;
                    end
                end else begin
                    w_presc_nxt = r_presc + 1'b1;
                end
            end
            S_HOLD: begin
                if (stop) begin
                    w_presc_nxt = '0;
                    w_count_nxt = '0;
                end
            end
            default: begin
                w_presc_nxt = '0;
                w_count_nxt = '0;
            end
        endcase
        w_busy_nxt      = (w_state_nxt == S_RUN) || (w_state_nxt == S_HOLD);
        w_cfg_ready_nxt = (w_state_nxt == S_IDLE) || (w_state_nxt == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc     <= '0;
            r_count     <= '0;
            r_tick      <= 1'b0;
            r_wrap      <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_cfg_ready <= 1'b1;
        end else begin
            r_presc     <= w_presc_nxt;
            r_count     <= w_count_nxt;
            r_tick      <= w_tick_nxt;
            r_wrap      <= w_wrap_nxt;
            r_done      <= w_done_nxt;
            r_busy      <= w_busy_nxt;
            r_cfg_ready <= w_cfg_ready_nxt;
        end
    end

    assign count     = r_count;
    assign tick      = r_tick;
    assign wrap      = r_wrap;
    assign done      = r_done;
    assign busy      = r_busy;
    assign cfg_ready = r_cfg_ready;

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer.
// Linear sequence of steps with hand-computed expectations.
module tb_count_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [3:0] cfg_limit;
    logic [7:0] cfg_prescale;
    logic       cfg_oneshot;
    logic       start;
    logic       stop;
    logic [3:0] count;
    logic       tick;
    logic       wrap;
    logic       done;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    count_sequencer #(
        .WIDTH(4),
        .PRESCALE_W(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_limit(cfg_limit),
        .cfg_prescale(cfg_prescale),
        .cfg_oneshot(cfg_oneshot),
        .start(start),
        .stop(stop),
        .count(count),
        .tick(tick),
        .wrap(wrap),
        .done(done),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset        = 1'b1;
        cfg_valid    = 1'b0;
        cfg_limit    = 4'd0;
        cfg_prescale = 8'd0;
        cfg_oneshot  = 1'b0;
        start        = 1'b0;
        stop         = 1'b0;
        #12;
        check("rst_count", 32'(count), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ready", 32'(cfg_ready), 1);
        check("rst_tick", 32'(tick), 0);
        @(negedge clk);
        reset = 1'b0;

        // 1: defaults, limit 15, prescale 0, continuous
        start = 1'b1;
        step();
        start = 1'b0;
        check("t1_count0", 32'(count), 0);
        check("t1_busy", 32'(busy), 1);
        check("t1_ready", 32'(cfg_ready), 0);
        check("t1_tick0", 32'(tick), 0);
        for (int k = 1; k <= 16; k++) begin
            step();
            check("t1_count", 32'(count), 32'(k % 16));
            check("t1_tick", 32'(tick), 1);
            check("t1_wrap", 32'(wrap), 32'(k == 16));
        end
        stop = 1'b1;
        step();
        check("t1_stop_count", 32'(count), 1);
        check("t1_stop_busy", 32'(busy), 1);
        step();
        stop = 1'b0;
        check("t1_idle_count", 32'(count), 0);
        check("t1_idle_busy", 32'(busy), 0);
        check("t1_idle_ready", 32'(cfg_ready), 1);

        // 2: limit 5, prescale 2, one-shot, cfg with start
        cfg_valid    = 1'b1;
        cfg_limit    = 4'd5;
        cfg_prescale = 8'd2;
        cfg_oneshot  = 1'b1;
        start        = 1'b1;
        step();
        cfg_valid = 1'b0;
        start     = 1'b0;
        check("t2_count0", 32'(count), 0);
        check("t2_busy0", 32'(busy), 1);
        for (int s = 1; s <= 18; s++) begin
            step();
            check("t2_tick", 32'(tick), 32'(s % 3 == 0));
            check("t2_count", 32'(count), 32'((s / 3 > 5) ? 5 : s / 3));
            check("t2_done", 32'(done), 32'(s == 18));
            check("t2_busy", 32'(busy), 32'(s < 18));
        end
        for (int s = 0; s < 2; s++) begin
            step();
            check("t2_hold_count", 32'(count), 5);
            check("t2_hold_done", 32'(done), 0);
            check("t2_hold_tick", 32'(tick), 0);
            check("t2_hold_ready", 32'(cfg_ready), 1);
        end

        // 3: limit 3 continuous, pause at 2, resume
        cfg_valid    = 1'b1;
        cfg_limit    = 4'd3;
        cfg_prescale = 8'd0;
        cfg_oneshot  = 1'b0;
        start        = 1'b1;
        step();
        cfg_valid = 1'b0;
        start     = 1'b0;
        check("t3_count0", 32'(count), 0);
        step();
        check("t3_count1", 32'(count), 1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("t3_stop_count", 32'(count), 2);
        check("t3_stop_tick", 32'(tick), 1);
        check("t3_stop_busy", 32'(busy), 1);
        cfg_valid    = 1'b1;
        cfg_limit    = 4'd7;
        for (int s = 0; s < 10; s++) begin
            step();
            check("t3_frz_count", 32'(count), 2);
            check("t3_frz_tick", 32'(tick), 0);
            check("t3_frz_ready", 32'(cfg_ready), 0);
        end
        cfg_valid = 1'b0;
        start     = 1'b1;
        step();
        start = 1'b0;
        check("t3_res_count", 32'(count), 2);
        check("t3_res_busy", 32'(busy), 1);
        step();
        check("t3_count3", 32'(count), 3);
        check("t3_nowrap", 32'(wrap), 0);
        step();
        check("t3_count_w", 32'(count), 0);
        check("t3_wrap", 32'(wrap), 1);

        // 4: cfg in RUN ignored, start+stop -> HOLD, stop -> IDLE
        cfg_valid    = 1'b1;
        cfg_limit    = 4'd1;
        cfg_prescale = 8'd5;
        cfg_oneshot  = 1'b1;
        step();
        cfg_valid = 1'b0;
        check("t4_count1", 32'(count), 1);
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        check("t4_ss_count", 32'(count), 2);
        check("t4_ss_tick", 32'(tick), 1);
        step();
        check("t4_hold_count", 32'(count), 2);
        check("t4_hold_busy", 32'(busy), 1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("t4_abort_count", 32'(count), 0);
        check("t4_abort_busy", 32'(busy), 0);
        check("t4_abort_ready", 32'(cfg_ready), 1);
        start = 1'b1;
        step();
        start = 1'b0;
        check("t4_rs_count", 32'(count), 0);
        step();
        check("t4_c1", 32'(count), 1);
        step();
        check("t4_c2", 32'(count), 2);
        step();
        check("t4_c3", 32'(count), 3);
        step();
        check("t4_c0", 32'(count), 0);
        check("t4_wrap", 32'(wrap), 1);
        stop = 1'b1;
        step();
        step();
        stop = 1'b0;
        check("t4_end_count", 32'(count), 0);
        check("t4_end_busy", 32'(busy), 0);

        // 5: limit 0 one-shot, then limit 0 continuous, async reset
        cfg_valid    = 1'b1;
        cfg_limit    = 4'd0;
        cfg_prescale = 8'd0;
        cfg_oneshot  = 1'b1;
        start        = 1'b1;
        step();
        cfg_valid = 1'b0;
        start     = 1'b0;
        check("t5_os_busy0", 32'(busy), 1);
        step();
        check("t5_os_done", 32'(done), 1);
        check("t5_os_tick", 32'(tick), 1);
        check("t5_os_wrap", 32'(wrap), 0);
        check("t5_os_count", 32'(count), 0);
        check("t5_os_busy", 32'(busy), 0);
        cfg_valid   = 1'b1;
        cfg_oneshot = 1'b0;
        start       = 1'b1;
        step();
        cfg_valid = 1'b0;
        start     = 1'b0;
        check("t5_c_tick0", 32'(tick), 0);
        for (int s = 0; s < 3; s++) begin
            step();
            check("t5_c_tick", 32'(tick), 1);
            check("t5_c_wrap", 32'(wrap), 1);
            check("t5_c_count", 32'(count), 0);
            check("t5_c_busy", 32'(busy), 1);
        end
        reset = 1'b1;
        #2;
        check("t5_ar_tick", 32'(tick), 0);
        check("t5_ar_wrap", 32'(wrap), 0);
        check("t5_ar_busy", 32'(busy), 0);
        check("t5_ar_ready", 32'(cfg_ready), 1);
        check("t5_ar_count", 32'(count), 0);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        check("t5_def_count0", 32'(count), 0);
        step();
        check("t5_def_count1", 32'(count), 1);
        check("t5_def_wrap", 32'(wrap), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
